// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - pixel writer valid/ready channel into the frame-buffer arbiter
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer port arbiter: scanout fetch, clear engine, pixel writer
module vga_fb_arbiter #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  vga_fb_arbiter_if.slave   wr_bus,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data
);
  localparam logic [9:0]        H_VIS0    = 10'd144;
  localparam logic [9:0]        H_VIS1    = 10'(144 + 4*FB_W - 1);
  localparam logic [9:0]        V_VIS0    = 10'd35;
  localparam logic [9:0]        V_VIS1    = 10'(35 + 4*FB_H - 1);
  localparam logic [9:0]        H_FET0    = H_VIS0 - 10'd2;
  localparam logic [9:0]        H_FET1    = H_VIS1 - 10'd5;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W*FB_H - 1);
  localparam logic [ADDR_W-1:0] N_WORDS   = ADDR_W'(FB_W*FB_H);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_addr;
  logic [DATA_W-1:0]   clr_fill;
  logic                fetch_d;
  logic [DATA_W-1:0]   pix_reg;

  logic                v_act;
  logic                h_vis;
  logic                fetch;
  logic [7:0]          fx;
  logic [6:0]          fy;
  logic [ADDR_W-1:0]   fetch_addr;

  // Fetch two pixels ahead of each 4-pixel cell so the read lands before it is shown.
  assign v_act = (vcount >= V_VIS0) && (vcount <= V_VIS1);
  assign h_vis = (hcount >= H_VIS0) && (hcount <= H_VIS1);
  assign fetch = v_act && (hcount >= H_FET0) && (hcount <= H_FET1) && (hcount[1:0] == 2'd2);

  assign fx         = 8'((hcount - H_FET0) >> 2);
  assign fy         = 7'((vcount - V_VIS0) >> 2);
  assign fetch_addr = ADDR_W'({fy, 7'b0}) + ADDR_W'({fy, 5'b0}) + ADDR_W'(fx);

  assign wr_bus.wr_ready = !reset && !fetch && !clr_busy;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (fetch) begin
      mem_addr = fetch_addr;
    end else if (clr_busy) begin
      mem_addr  = clr_addr;
      mem_wdata = clr_fill;
      mem_we    = !reset;
    end else if (wr_bus.wr_valid && !reset) begin
      // Out-of-range writes still complete the handshake but never reach the RAM.
      mem_addr  = wr_bus.wr_addr;
      mem_wdata = wr_bus.wr_data;
      mem_we    = (wr_bus.wr_addr < N_WORDS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      clr_addr <= '0;
      clr_fill <= '0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            clr_addr <= '0;
            clr_fill <= clr_color;
          end
        end
        CLEAR: begin
          if (!fetch) begin
            if (clr_addr == LAST_ADDR) begin
              state    <= DONE;
              clr_busy <= 1'b0;
              clr_done <= 1'b1;
            end else begin
              clr_addr <= clr_addr + ADDR_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_d <= 1'b0;
      pix_reg <= '0;
    end else begin
      fetch_d <= fetch;
      if (fetch_d) pix_reg <= mem_rdata;
    end
  end

  assign pix_data = (h_vis && v_act) ? pix_reg : '0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - randomized bench for vga_fb_arbiter against a behavioural model
module tb_vga_fb_arbiter;
  localparam int NW = 19200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  hcount = 10'd150;
  logic [9:0]  vcount = 10'd40;
  logic        clr_start = 1'b0;
  logic [7:0]  clr_color = 8'h00;
  logic        clr_busy, clr_done, mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, pix_data;

  vga_fb_arbiter_if wr_bus ();

  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .wr_bus(wr_bus), .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .pix_data(pix_data)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [NW];
  always @(posedge clk) begin
    if (mem_we && int'(mem_addr) < NW) ram[mem_addr] <= mem_wdata;
    mem_rdata <= (int'(mem_addr) < NW) ? ram[mem_addr] : 8'h00;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)",
                  name, got, exp, hcount, vcount, $time);
  endtask

  // Behavioural model: frame contents, clear progress, pixel latency
  logic [7:0] shadow [NW];
  bit   m_active = 0, m_done = 0, pend = 0, hs = 0;
  int   m_next = 0, m_color = 0, m_pix = 0, pend_val = 0;
  int   clr_wr_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    int  h, v, fa, e_addr, e_data, e_pix;
    bit  is_f, win, e_ready, e_we, new_done;
    h    = int'(hcount);
    v    = int'(vcount);
    is_f = (v >= 35 && v <= 514 && h >= 142 && h <= 778 && (h % 4) == 2);
    fa   = ((v - 35) / 4) * 160 + (h - 142) / 4;
    win  = (h >= 144 && h <= 783 && v >= 35 && v <= 514);
    e_ready = !reset && !is_f && !m_active;
    e_pix   = win ? m_pix : 0;
    e_we = 0; e_addr = 0; e_data = 0;
    if (!reset && !is_f) begin
      if (m_active) begin
        e_we = 1; e_addr = m_next; e_data = m_color;
      end else if (wr_bus.wr_valid && int'(wr_bus.wr_addr) < NW) begin
        e_we = 1; e_addr = int'(wr_bus.wr_addr); e_data = int'(wr_bus.wr_data);
      end
    end

    check("wr_ready", wr_bus.wr_ready, e_ready);
    check("clr_busy", clr_busy, m_active);
    check("clr_done", clr_done, m_done);
    check("pix_data", pix_data, e_pix);
    check("mem_we", mem_we, e_we);
    if (!reset && is_f) check("fetch_addr", mem_addr, fa);
    if (e_we) begin
      check("wr_addr", mem_addr, e_addr);
      check("wr_data", mem_wdata, e_data);
    end

    if (mem_we && clr_busy) clr_wr_cnt++;
    if (clr_done) done_cnt++;
    hs = wr_bus.wr_valid && e_ready;

    if (reset) begin
      m_pix = 0; pend = 0;
    end else begin
      if (pend) m_pix = pend_val;
      pend = is_f;
      if (is_f) pend_val = shadow[fa];
    end
    if (e_we) shadow[e_addr] = e_data[7:0];

    new_done = 0;
    if (reset) begin
      m_active = 0;
    end else if (m_active) begin
      if (!is_f) begin
        if (m_next == NW - 1) begin
          m_active = 0; new_done = 1;
        end else m_next++;
      end
    end else if (!m_done && clr_start) begin
      m_active = 1; m_next = 0; m_color = int'(clr_color);
    end
    m_done = reset ? 0 : new_done;
  end

  bit adv = 0;
  int wmode = 0;

  task automatic step();
    int r;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    if (adv) begin
      if (hcount == 10'd799) begin
        hcount = 10'd0;
        vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
      end else hcount = hcount + 10'd1;
    end
    if (wmode == 1) begin
      if (!wr_bus.wr_valid || hs) begin
        wr_bus.wr_valid = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        wr_bus.wr_addr = (r == 0) ? 15'($urandom_range(19195, 19210)) :
                         (r == 1) ? 15'($urandom_range(0, 32767)) :
                                    15'($urandom_range(0, 799));
        wr_bus.wr_data = 8'($urandom);
      end
    end else if (wmode == 0) begin
      wr_bus.wr_valid = 1'b0;
    end
  endtask

  initial begin
    int k, bad, base, done_base;
    for (int i = 0; i < NW; i++) begin
      ram[i] = 8'h00; shadow[i] = 8'h00;
    end
    ram[0] = 8'h11; shadow[0] = 8'h11;
    ram[1] = 8'h22; shadow[1] = 8'h22;
    ram[160] = 8'h33; shadow[160] = 8'h33;
    wr_bus.wr_valid = 1'b0; wr_bus.wr_addr = '0; wr_bus.wr_data = '0;

    repeat (3) step();
    @(negedge clk);
    check("rst_pix", pix_data, 8'h00);
    check("rst_ready", wr_bus.wr_ready, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_busy", clr_busy, 1'b0);
    step();
    reset = 1'b0;
    adv = 1;
    hcount = 10'd140; vcount = 10'd35;

    repeat (14) begin
      @(negedge clk);
      if (hcount == 10'd142) check("scan_addr0", mem_addr, 15'd0);
      if (hcount >= 10'd144 && hcount <= 10'd147) check("scan_pix0", pix_data, 8'h11);
      if (hcount >= 10'd148 && hcount <= 10'd151) check("scan_pix1", pix_data, 8'h22);
      step();
    end
    hcount = 10'd140; vcount = 10'd39;
    repeat (8) begin
      @(negedge clk);
      if (hcount == 10'd144) check("scan_pix160", pix_data, 8'h33);
      if (hcount == 10'd146) check("scan_addr161", mem_addr, 15'd161);
      step();
    end

    wmode = 2;
    hcount = 10'd146; vcount = 10'd35;
    wr_bus.wr_valid = 1'b1; wr_bus.wr_addr = 15'd5; wr_bus.wr_data = 8'h77;
    @(negedge clk);
    check("arb_blocked", wr_bus.wr_ready, 1'b0);
    step();
    @(negedge clk);
    check("arb_granted", wr_bus.wr_ready, 1'b1);
    check("arb_we", mem_we, 1'b1);
    check("arb_addr", mem_addr, 15'd5);
    step();
    hcount = 10'd0; vcount = 10'd520;
    wr_bus.wr_addr = 15'd19200; wr_bus.wr_data = 8'h5A;
    @(negedge clk);
    check("oob_ready", wr_bus.wr_ready, 1'b1);
    check("oob_we", mem_we, 1'b0);
    step();

    wmode = 1;
    hcount = 10'd600; vcount = 10'd33;
    repeat (3000) step();

    wmode = 2;
    hcount = 10'd0; vcount = 10'd515;
    wr_bus.wr_valid = 1'b1; wr_bus.wr_addr = 15'd300; wr_bus.wr_data = 8'h3C;
    clr_start = 1'b1; clr_color = 8'hA5;
    base = clr_wr_cnt; done_base = done_cnt;
    @(negedge clk);
    check("coinc_we", mem_we, 1'b1);
    check("coinc_addr", mem_addr, 15'd300);
    step();
    @(negedge clk);
    check("clr_first_ready", wr_bus.wr_ready, 1'b0);
    check("clr_first_addr", mem_addr, 15'd0);
    check("clr_first_data", mem_wdata, 8'hA5);
    wmode = 0;
    k = 0;
    while (done_cnt == done_base && k < 25000) begin
      step();
      k++;
      if (k == 5000) begin
        clr_start = 1'b1; clr_color = 8'h00;
      end
    end
    check("clr_done_seen", done_cnt - done_base, 1);
    check("clr_write_count", clr_wr_cnt - base, NW);
    repeat (3) step();
    @(negedge clk);
    check("clr_single_done", done_cnt - done_base, 1);
    bad = 0;
    for (int i = 0; i < NW; i++) if (ram[i] !== 8'hA5) bad++;
    check("ram_all_a5", bad, 0);

    hcount = 10'd0; vcount = 10'd35;
    repeat (1600) begin
      @(negedge clk);
      if (hcount >= 10'd144 && hcount <= 10'd783) check("frame_a5", pix_data, 8'hA5);
      step();
    end
    hcount = 10'd0; vcount = 10'd514;
    repeat (800) begin
      @(negedge clk);
      if (hcount >= 10'd144 && hcount <= 10'd783) check("frame_a5_last", pix_data, 8'hA5);
      step();
    end

    hcount = 10'd0; vcount = 10'd515;
    clr_start = 1'b1; clr_color = 8'h3C;
    base = clr_wr_cnt; done_base = done_cnt;
    k = 0;
    while (clr_wr_cnt - base < 500 && k < 1000) begin
      step();
      k++;
    end
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", clr_busy, 1'b0);
    check("abort_writes", clr_wr_cnt - base, 500);
    check("abort_no_done", done_cnt - done_base, 0);
    clr_start = 1'b1; clr_color = 8'h5A;
    step();
    @(negedge clk);
    check("restart_busy", clr_busy, 1'b1);
    check("restart_we", mem_we, 1'b1);
    check("restart_addr", mem_addr, 15'd0);
    repeat (100) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
